nes_pad_reader: RTL
===================

# nes_pad_reader

Polls one NES-style serial gamepad, debounces the eight buttons, and presents them as a parallel word with per-button press edges. One instance per player sits directly upstream of the game statemachine and drives its controller input. It generates the pad's latch and clock lines, samples the pad's serial data, and issues a one-cycle `valid` strobe per completed poll.

## Interface
- `HALF_PERIOD`, default 648: clocks per pad_clk half period (6 us at 108 MHz); must be ≥ 4.
- `POLL_CYCLES`, default 1800500: clocks between poll starts (≈60 Hz at 108 MHz); must be > 18*HALF_PERIOD + 4.
- `clock`, input, 1: system clock; all state on rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `pad_data`, input, 1: serial data from pad, active-low (0 = pressed), asynchronous to `clock`.
- `pad_latch`, output, 1: latch pulse to pad, active-high, registered.
- `pad_clk`, output, 1: shift clock to pad, registered.
- `buttons`, output, 8: debounced state, 1 = pressed; [7]=A, [6]=B, [5]=Select, [4]=Start, [3]=Up, [2]=Down, [1]=Left, [0]=Right.
- `pressed`, output, 8: buttons that went 0→1 on the latest update; valid only with `valid`.
- `valid`, output, 1: one-cycle strobe when `buttons`/`pressed` update.

## Operation
- `pad_data` passes through a 2-flop synchronizer; all sampling uses the synchronized value, inverted to active-high.
- Poll timer counts 0..POLL_CYCLES-1 and wraps. On wrap, a poll starts if the FSM is in IDLE; otherwise the start request is dropped and not queued.
- FSM states:
  - IDLE: latch=0, clk=0. Moves to LATCH on a timer wrap.
  - LATCH: latch=1, clk=0, for exactly 2*HALF_PERIOD cycles. Then SLOT_LO with bit=0.
  - SLOT_LO: latch=0, clk=0, for HALF_PERIOD cycles. On its last cycle, sample the synchronized bit into raw[7-bit].
  - SLOT_HI: clk=1 for HALF_PERIOD cycles. Then go to SLOT_LO with bit+1, or to DONE after bit 7.
  - DONE: single cycle; updates the outputs and returns to IDLE.
- Each poll produces exactly 8 pad_clk rising edges; the last one is harmless to the pad.
- Debounce in DONE, per bit i:
  - if raw[i]==prev_raw[i], the new buttons[i] = raw[i]; otherwise buttons[i] holds.
  - pressed = new_buttons & ~old_buttons.
  - prev_raw <= raw.
  - valid=1 for that cycle only.
- `pressed` holds its value until the next DONE. Consumers qualify it with `valid`.

## Timing
- Reset values: pad_latch 0, pad_clk 0, buttons 8'h00, pressed 8'h00, valid 0. prev_raw, raw, and the synchronizer are 0; timer 0; FSM IDLE.
- First poll starts at the wrap POLL_CYCLES cycles after reset release. LATCH is entered on the following edge.
- Poll length from LATCH entry to DONE is 18*HALF_PERIOD cycles; DONE takes 1 cycle.
- A button change needs two consecutive agreeing polls to reach `buttons`, so worst-case latency is about 2*POLL_CYCLES + 18*HALF_PERIOD + 3.
- Asserting reset mid-poll returns all outputs to reset values immediately and aborts the poll. Timer restarts from 0.
- A button toggling between two polls updates nothing until it holds for two consecutive polls.

## Test plan
Bench settings: HALF_PERIOD=4, POLL_CYCLES=100. Behavioral pad model: 8-bit shift register loaded on pad_latch high, shifted on pad_clk rising, `pad_data` = ~current bit.

- Reset, then hold 50 cycles → pad_latch=0, pad_clk=0, buttons=00, pressed=00, valid=0 throughout.
- Pad holds A+Start (8'h90) from reset:
  - poll 1 → valid, buttons=00, pressed=00.
  - poll 2 → buttons=90, pressed=90.
  - poll 3 → buttons=90, pressed=00.
- Each poll → pad_latch high exactly 8 cycles, exactly 8 pad_clk rising edges with 4-cycle high/low phases, exactly one valid per 100 cycles.
- Stable 00, then a single poll reading 8'h01, then 00 again → buttons stays 00 and pressed stays 00 on every valid.
- Stable 90, then pad 10 (A released) → after two polls buttons=10, pressed=00; then Right pressed (8'h11) → two polls later buttons=11, pressed=01.
- Assert reset during the fourth SLOT_HI → pad_clk and pad_latch drop to 0 that cycle, buttons=00. After release, the next LATCH starts 100 cycles later.

Source files
------------

// File: rtl/nes_pad_reader.sv
// nes_pad_reader: polls one NES pad, debounces 8 buttons, reports edges.
// Ports: clock/reset(async low), pad_data in; pad_latch/pad_clk, buttons/pressed/valid out.
module nes_pad_reader #(
  parameter int HALF_PERIOD = 648,
  parameter int POLL_CYCLES = 1800500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons,
  output logic [7:0] pressed,
  output logic       valid
);

  localparam int TW = $clog2(POLL_CYCLES);
  localparam int PW = $clog2(2 * HALF_PERIOD);
  localparam logic [TW-1:0] T_LAST = TW'(POLL_CYCLES - 1);
  localparam logic [PW-1:0] H_LAST = PW'(HALF_PERIOD - 1);
  localparam logic [PW-1:0] L_LAST = PW'(2 * HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SLOT_LO,
    SLOT_HI,
    DONE
  } state_t;

  state_t        state;
  logic [1:0]    sync;
  logic [TW-1:0] timer;
  logic [PW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    raw;
  logic [7:0]    prev_raw;
  logic [7:0]    agree;
  logic [7:0]    next_buttons;
  logic          sample;
  logic          wrap;

  assign sample = ~sync[1];
  assign wrap   = (timer == T_LAST);

  // A bit only moves when two consecutive polls agree on it.
  assign agree        = ~(raw ^ prev_raw);
  assign next_buttons = (raw & agree) | (buttons & ~agree);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], pad_data};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer <= '0;
    end else if (wrap) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      raw       <= 8'h00;
      prev_raw  <= 8'h00;
      pad_latch <= 1'b0;
      pad_clk   <= 1'b0;
      buttons   <= 8'h00;
      pressed   <= 8'h00;
      valid     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          valid <= 1'b0;
          // Wraps seen outside IDLE are simply lost.
          if (wrap) begin
            state     <= LATCH;
            pad_latch <= 1'b1;
            cnt       <= '0;
          end
        end
        LATCH: begin
          if (cnt == L_LAST) begin
            state     <= SLOT_LO;
            pad_latch <= 1'b0;
            cnt       <= '0;
            bit_idx   <= 3'd0;
          end else begin
            cnt <= cnt + PW'(1);
          end
        end
        SLOT_LO: begin
          if (cnt == H_LAST) begin
            raw[3'd7 - bit_idx] <= sample;
            state   <= SLOT_HI;
            pad_clk <= 1'b1;
            cnt     <= '0;
          end else begin
            cnt <= cnt + PW'(1);
          end
        end
        SLOT_HI: begin
          if (cnt == H_LAST) begin
            pad_clk <= 1'b0;
            cnt     <= '0;
            if (bit_idx == 3'd7) begin
              // Outputs land as DONE is entered so valid marks DONE.
              state    <= DONE;
              buttons  <= next_buttons;
              pressed  <= next_buttons & ~buttons;
              prev_raw <= raw;
              valid    <= 1'b1;
            end else begin
              state   <= SLOT_LO;
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + PW'(1);
          end
        end
        DONE: begin
          valid <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
